// File: rtl/tv80_busarb_pkg.sv
// Shared definitions for the TV80 bus-mastership arbiter: state encoding,
// default parameter values and the width of the round-robin pointer.
package tv80_busarb_pkg;

    localparam int NUM_REQ_DEF  = 2;
    localparam int MAX_HOLD_DEF = 64;
    localparam int CPU_GAP_DEF  = 4;
    localparam int CNT_W_DEF    = 8;

    // Pointer width covers the full 1..8 requester range.
    localparam int IDX_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_GRANT   = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_RELEASE = 3'd4,
        ST_GAP     = 3'd5
    } state_e;

endpackage

// File: rtl/tv80_rr_pick.sv
// Combinational round-robin picker: returns the first set request strictly
// above i_last, wrapping to the lowest set request if none is found above.
module tv80_rr_pick
    import tv80_busarb_pkg::*;
#(
    parameter int NumReq = NUM_REQ_DEF
) (
    input  logic [NumReq-1:0] i_req,
    input  logic [IDX_W-1:0]  i_last,
    output logic [NumReq-1:0] o_gnt,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_valid
);

    logic w_found;

    // Two passes: upper window (above last) first, then wrap from index 0.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            if (!w_found && i_req[k] && (k > int'(i_last))) begin
                o_gnt[k] = 1'b1;
                o_idx    = IDX_W'(k);
                w_found  = 1'b1;
            end
        end
        for (int k = 0; k < NumReq; k++) begin
            if (!w_found && i_req[k]) begin
                o_gnt[k] = 1'b1;
                o_idx    = IDX_W'(k);
                w_found  = 1'b1;
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/tv80_busarb.sv
// Bus-mastership arbiter between the TV80 CPU and NumReq DMA-style requesters.
// Requests the bus from the CPU via busrq_n, grants one requester (round-robin)
// once busak_n is low, limits tenure to MaxHold cycles and keeps the CPU on the
// bus for at least CpuGap cycles between tenures.
module tv80_busarb
    import tv80_busarb_pkg::*;
#(
    parameter int NumReq  = NUM_REQ_DEF,
    parameter int MaxHold = MAX_HOLD_DEF,
    parameter int CpuGap  = CPU_GAP_DEF,
    parameter int CntW    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NumReq-1:0] req,
    input  logic              busak_n,
    output logic              busrq_n,
    output logic [NumReq-1:0] gnt,
    output logic              bus_owned,
    output logic              preempt,
    output state_e            o_dbg_state
);

    localparam logic [CntW-1:0] HoldLast = CntW'(MaxHold - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(CpuGap - 1);

    state_e            r_state;
    logic              r_busrq_n;
    logic [NumReq-1:0] r_gnt;
    logic              r_preempt;
    logic [IDX_W-1:0]  r_last;
    // Shared counter: hold cycles in GRANT, busak_n-high samples in RELEASE,
    // gap cycles in GAP. The states are exclusive so one register suffices.
    logic [CntW-1:0]   r_cnt;

    state_e            w_state_nxt;
    logic              w_busrq_n_nxt;
    logic [NumReq-1:0] w_gnt_nxt;
    logic              w_preempt_nxt;
    logic [IDX_W-1:0]  w_last_nxt;
    logic [CntW-1:0]   w_cnt_nxt;
    logic [NumReq-1:0] w_pick_gnt;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_pick_valid;
    logic              w_req_any;
    logic              w_win_req;

    assign w_req_any = |req;
    assign w_win_req = |(req & r_gnt);

    tv80_rr_pick #(
        .NumReq (NumReq)
    ) u_pick (
        .i_req   (req),
        .i_last  (r_last),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        w_state_nxt   = r_state;
        w_busrq_n_nxt = r_busrq_n;
        w_gnt_nxt     = r_gnt;
        w_preempt_nxt = 1'b0;
        w_last_nxt    = r_last;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_state_nxt   = ST_REQ;
                    w_busrq_n_nxt = 1'b0;
                end
            end
            ST_REQ: begin
                if (!w_req_any) begin
                    // Abort: everyone went away before the acknowledge.
                    w_state_nxt   = ST_RELEASE;
                    w_busrq_n_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                end else if (!busak_n && w_pick_valid) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = w_pick_gnt;
                    w_last_nxt  = w_pick_idx;
                    w_cnt_nxt   = '0;
                end
            end
            ST_GRANT: begin
                // CPU protocol error or requester done: a normal drop wins
                // over preemption when both happen on the same edge.
                if (busak_n || !w_win_req) begin
                    w_state_nxt = ST_DRAIN;
                    w_gnt_nxt   = '0;
                end else if ((MaxHold != 0) && (r_cnt == HoldLast)) begin
                    w_state_nxt   = ST_DRAIN;
                    w_gnt_nxt     = '0;
                    w_preempt_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
            end
            ST_DRAIN: begin
                // One turnaround cycle with gnt low while busrq_n stays low.
                w_state_nxt   = ST_RELEASE;
                w_busrq_n_nxt = 1'b1;
                w_cnt_nxt     = '0;
            end
            ST_RELEASE: begin
                // Need busak_n high on two consecutive edges to absorb a late
                // acknowledge after an abort.
                if (busak_n) begin
                    if (r_cnt != '0) begin
                        w_state_nxt = (CpuGap != 0) ? ST_GAP : ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = CntW'(1);
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            ST_GAP: begin
                if (r_cnt == GapLast) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_busrq_n_nxt = 1'b1;
                w_gnt_nxt     = '0;
                w_cnt_nxt     = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_busrq_n <= 1'b1;
            r_gnt     <= '0;
            r_preempt <= 1'b0;
            r_last    <= IDX_W'(NumReq - 1);
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_busrq_n <= w_busrq_n_nxt;
            r_gnt     <= w_gnt_nxt;
            r_preempt <= w_preempt_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign busrq_n     = r_busrq_n;
    assign gnt         = r_gnt;
    assign bus_owned   = |r_gnt;
    assign preempt     = r_preempt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tv80_busarb.sv
// Bench for tv80_busarb. Two instances share clock and reset: dut_a has
// unlimited tenure (MaxHold=0), dut_p preempts after 8 cycles. Tenures are
// recorded as {gnt, length, preempt-at-fall} and matched against a queue.
module tb_tv80_busarb;
  import tv80_busarb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- dut_a signals ----------------
  logic [1:0] req_a, req_drv_a, rr_req;
  logic       busak_a, man_ak_a, cpu_auto_a, rr_mode;
  logic       auto_ak_a = 1'b1;
  logic       busrq_n_a, bus_owned_a, preempt_a;
  logic [1:0] gnt_a;
  state_e     st_a;

  // ---------------- dut_p signals ----------------
  logic [1:0] req_p;
  logic       busak_p;
  logic       auto_ak_p = 1'b1;
  logic       busrq_n_p, bus_owned_p, preempt_p;
  logic [1:0] gnt_p;
  state_e     st_p;

  assign req_a   = rr_mode ? rr_req : req_drv_a;
  assign busak_a = cpu_auto_a ? auto_ak_a : man_ak_a;
  assign busak_p = auto_ak_p;

  tv80_busarb #(.NumReq(2), .MaxHold(0), .CpuGap(4), .CntW(8)) u_dut_a (
    .clk         (clk),
    .reset_n     (rst_n),
    .req         (req_a),
    .busak_n     (busak_a),
    .busrq_n     (busrq_n_a),
    .gnt         (gnt_a),
    .bus_owned   (bus_owned_a),
    .preempt     (preempt_a),
    .o_dbg_state (st_a)
  );

  tv80_busarb #(.NumReq(2), .MaxHold(8), .CpuGap(4), .CntW(8)) u_dut_p (
    .clk         (clk),
    .reset_n     (rst_n),
    .req         (req_p),
    .busak_n     (busak_p),
    .busrq_n     (busrq_n_p),
    .gnt         (gnt_p),
    .bus_owned   (bus_owned_p),
    .preempt     (preempt_p),
    .o_dbg_state (st_p)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [10:0] exp_a_q[$];
  logic [10:0] exp_p_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- CPU models ----------------
  // Acknowledge three cycles after busrq_n falls, release as soon as it rises.
  int a_lo = 0;
  int p_lo = 0;
  always @(negedge clk) begin
    if (busrq_n_a) begin a_lo = 0; auto_ak_a = 1'b1; end
    else begin a_lo++; if (a_lo >= 3) auto_ak_a = 1'b0; end
    if (busrq_n_p) begin p_lo = 0; auto_ak_p = 1'b1; end
    else begin p_lo++; if (p_lo >= 3) auto_ak_p = 1'b0; end
  end

  // Round-robin requesters: both want the bus; the owner drops req for one
  // cycle after five grant cycles and reasserts immediately.
  int rr_cnt = 0;
  always @(negedge clk) begin
    if (!rr_mode) begin
      rr_req = 2'b11;
      rr_cnt = 0;
    end else begin
      rr_req = 2'b11;
      if (gnt_a != 2'b00) begin
        rr_cnt++;
        if (rr_cnt == 5) begin
          rr_req = ~gnt_a;
          rr_cnt = 0;
        end
      end
    end
  end

  // ---------------- monitors ----------------
  logic [1:0] a_prev = 2'b00;
  int         a_len  = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      a_prev = 2'b00;
      a_len  = 0;
    end else begin
      chk("a_onehot", 32'($onehot0(gnt_a)), 32'd1);
      chk("a_owned", 32'(bus_owned_a), 32'(|gnt_a));
      chk("a_no_preempt", 32'(preempt_a), 32'd0);
      if (gnt_a != 2'b00) begin
        chk("a_gnt_busrq", 32'(busrq_n_a), 32'd0);
        chk("a_gnt_state", 32'(st_a), 32'(ST_GRANT));
        if (a_prev != 2'b00) chk("a_gnt_stable", 32'(gnt_a), 32'(a_prev));
        else a_len = 0;
        a_len++;
      end else if (a_prev != 2'b00) begin
        if (exp_a_q.size() == 0) chk("a_tenure_extra", 32'(a_prev), 32'd0);
        else chk("a_tenure", 32'({a_prev, 8'(a_len), preempt_a}), 32'(exp_a_q.pop_front()));
      end
      a_prev = gnt_a;
    end
  end

  logic [1:0] p_prev = 2'b00;
  int         p_len  = 0;
  int         p_hi   = 0;
  int         p_ten  = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_prev = 2'b00;
      p_len  = 0;
      p_hi   = 0;
    end else begin
      chk("p_owned", 32'(bus_owned_p), 32'(|gnt_p));
      if (gnt_p != 2'b00) begin
        if (p_prev == 2'b00) begin
          p_len = 0;
          if (p_ten > 0) chk("p_cpu_gap_ge4", 32'(p_hi >= 4), 32'd1);
          p_hi = 0;
        end
        p_len++;
        chk("p_preempt_mid", 32'(preempt_p), 32'd0);
      end else if (p_prev != 2'b00) begin
        p_ten++;
        if (exp_p_q.size() == 0) chk("p_tenure_extra", 32'(p_prev), 32'd0);
        else chk("p_tenure", 32'({p_prev, 8'(p_len), preempt_p}), 32'(exp_p_q.pop_front()));
      end else begin
        chk("p_preempt_idle", 32'(preempt_p), 32'd0);
        if (busrq_n_p) p_hi++;
      end
      p_prev = gnt_p;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_state_a(input state_e s, input string tag);
    int n = 0;
    while (st_a != s && n < 200) begin step(); n++; end
    chk(tag, 32'(st_a), 32'(s));
  endtask

  task automatic wait_gnt_a(input string tag);
    int n = 0;
    while (gnt_a == 2'b00 && n < 200) begin step(); n++; end
    chk(tag, 32'(gnt_a != 2'b00), 32'd1);
  endtask

  task automatic wait_q_a(input string tag);
    int n = 0;
    while (exp_a_q.size() != 0 && n < 600) begin step(); n++; end
    chk(tag, 32'(exp_a_q.size()), 32'd0);
  endtask

  task automatic wait_q_p(input string tag);
    int n = 0;
    while (exp_p_q.size() != 0 && n < 600) begin step(); n++; end
    chk(tag, 32'(exp_p_q.size()), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    req_drv_a  = 2'b00;
    man_ak_a   = 1'b1;
    cpu_auto_a = 1'b1;
    rr_mode    = 1'b0;
    req_p      = 2'b00;
    rst_n      = 1'b0;
    repeat (3) step();

    chk("rst_busrq", 32'(busrq_n_a), 32'd1);
    chk("rst_gnt", 32'(gnt_a), 32'd0);
    chk("rst_owned", 32'(bus_owned_a), 32'd0);
    chk("rst_state", 32'(st_a), 32'(ST_IDLE));
    rst_n = 1'b1;
    step();

    // Single request: 10 grant cycles, drain, release, 4 gap cycles.
    exp_a_q.push_back({2'b01, 8'd10, 1'b0});
    req_drv_a = 2'b01;
    step();
    chk("single_rq_lat", 32'(busrq_n_a), 32'd0);
    n = 0;
    while (busak_a && n < 20) begin step(); n++; end
    chk("single_ak_seen", 32'(busak_a), 32'd0);
    chk("single_gnt_pre", 32'(gnt_a), 32'd0);
    step();
    chk("single_gnt_lat", 32'(gnt_a), 32'd1);
    for (int i = 1; i < 10; i++) step();
    req_drv_a = 2'b00;
    step();
    chk("single_drain_gnt", 32'(gnt_a), 32'd0);
    chk("single_drain_rq", 32'(busrq_n_a), 32'd0);
    chk("single_drain_st", 32'(st_a), 32'(ST_DRAIN));
    step();
    chk("single_rel_rq", 32'(busrq_n_a), 32'd1);
    chk("single_rel_st", 32'(st_a), 32'(ST_RELEASE));
    wait_state_a(ST_GAP, "single_gap_enter");
    n = 0;
    while (st_a == ST_GAP && n < 20) begin n++; step(); end
    chk("single_gap_len", 32'(n), 32'd4);
    chk("single_idle", 32'(st_a), 32'(ST_IDLE));

    // Preemption on dut_p: two 8-cycle tenures, each ending with preempt.
    exp_p_q.push_back({2'b01, 8'd8, 1'b1});
    exp_p_q.push_back({2'b01, 8'd8, 1'b1});
    req_p = 2'b01;
    wait_q_p("preempt_done");
    req_p = 2'b00;

    // Protocol error: busak_n rises after 3 grant cycles.
    wait_state_a(ST_IDLE, "perr_idle");
    exp_a_q.push_back({2'b01, 8'd3, 1'b0});
    req_drv_a = 2'b01;
    wait_gnt_a("perr_gnt");
    step();
    step();
    cpu_auto_a = 1'b0;
    man_ak_a   = 1'b1;
    step();
    chk("perr_gnt_drop", 32'(gnt_a), 32'd0);
    chk("perr_no_preempt", 32'(preempt_a), 32'd0);
    chk("perr_drain_st", 32'(st_a), 32'(ST_DRAIN));
    chk("perr_drain_rq", 32'(busrq_n_a), 32'd0);
    req_drv_a = 2'b00;
    step();
    chk("perr_rel_st", 32'(st_a), 32'(ST_RELEASE));
    chk("perr_rel_rq", 32'(busrq_n_a), 32'd1);
    wait_state_a(ST_IDLE, "perr_back_idle");

    // Abort before acknowledge, then a late acknowledge held in RELEASE.
    req_drv_a = 2'b01;
    step();
    chk("abort_rq", 32'(busrq_n_a), 32'd0);
    step();
    req_drv_a = 2'b00;
    step();
    chk("abort_rel_rq", 32'(busrq_n_a), 32'd1);
    chk("abort_rel_st", 32'(st_a), 32'(ST_RELEASE));
    man_ak_a = 1'b0;
    step();
    chk("abort_hold_st1", 32'(st_a), 32'(ST_RELEASE));
    chk("abort_gnt", 32'(gnt_a), 32'd0);
    step();
    man_ak_a = 1'b1;
    chk("abort_hold_st2", 32'(st_a), 32'(ST_RELEASE));
    step();
    chk("abort_hold_st3", 32'(st_a), 32'(ST_RELEASE));
    step();
    chk("abort_gap_st", 32'(st_a), 32'(ST_GAP));
    chk("abort_gap_rq", 32'(busrq_n_a), 32'd1);
    wait_state_a(ST_IDLE, "abort_idle");
    cpu_auto_a = 1'b1;

    // Reset mid-tenure, then round-robin starting from req[0].
    req_drv_a = 2'b11;
    wait_gnt_a("rst_mid_gnt");
    step();
    rst_n = 1'b0;
    step();
    chk("rst_mid_busrq", 32'(busrq_n_a), 32'd1);
    chk("rst_mid_gnt", 32'(gnt_a), 32'd0);
    chk("rst_mid_owned", 32'(bus_owned_a), 32'd0);
    chk("rst_mid_preempt", 32'(preempt_a), 32'd0);
    chk("rst_mid_state", 32'(st_a), 32'(ST_IDLE));
    rr_mode = 1'b1;
    exp_a_q.push_back({2'b01, 8'd5, 1'b0});
    exp_a_q.push_back({2'b10, 8'd5, 1'b0});
    exp_a_q.push_back({2'b01, 8'd5, 1'b0});
    exp_a_q.push_back({2'b10, 8'd5, 1'b0});
    step();
    rst_n = 1'b1;
    wait_q_a("rr_done");
    rr_mode   = 1'b0;
    req_drv_a = 2'b00;
    wait_state_a(ST_IDLE, "final_idle_a");
    repeat (4) step();

    chk("a_q_drained", 32'(exp_a_q.size()), 32'd0);
    chk("p_q_drained", 32'(exp_p_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
